// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad scanner.
//   kp_state_t    : debounce FSM states
//   frame_class_t : how many keys one full scan frame saw
//   KEY_MAP       : [row][col] -> hex value, PmodKYPD layout
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} kp_state_t;

  typedef enum logic [1:0] {EMPTY, SINGLE, MULTI} frame_class_t;

  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

endpackage

// File: rtl/hex_keypad_scanner_if.sv
// Key-entry bus between the keypad scanner and its consumer.
//   clear_in      : synchronous clear of val_out
//   key_valid_out : one-cycle pulse per accepted press
//   key_out       : most recently accepted key
//   key_held_out  : a key is accepted and not yet released
//   val_out       : shifted-in digits, newest in [3:0]
interface hex_keypad_scanner_if;
  logic        clear_in;
  logic        key_valid_out;
  logic [3:0]  key_out;
  logic        key_held_out;
  logic [31:0] val_out;

  modport master (input clear_in, output key_valid_out, key_out, key_held_out, val_out);
  modport slave  (output clear_in, input key_valid_out, key_out, key_held_out, val_out);
endinterface

// File: rtl/keypad_debounce.sv
// Frame-granular debounce FSM for the keypad scanner.
//   clk_in, rst_in : clock, synchronous active-high reset
//   frame_strobe   : one cycle at each frame end
//   frame_class    : EMPTY / SINGLE / MULTI for the ending frame
//   frame_key      : decoded key when frame_class == SINGLE
//   clear          : zero the entry register next cycle
//   accept         : one-cycle pulse per accepted press
//   key            : last accepted key
//   held           : FSM in HELD or RELEASE
//   val            : entry shift register, newest digit in [3:0]
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         frame_strobe,
  input  frame_class_t frame_class,
  input  logic [3:0]   frame_key,
  input  logic         clear,
  output logic         accept,
  output logic [3:0]   key,
  output logic         held,
  output logic [31:0]  val
);

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  kp_state_t  state;
  logic [3:0] cand;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;

  // cnt never runs past DF
  assign cnt_inc = (cnt == DF) ? DF : cnt + 4'd1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= IDLE;
      cand   <= '0;
      cnt    <= '0;
      accept <= 1'b0;
      key    <= '0;
      held   <= 1'b0;
      val    <= '0;
    end else begin
      accept <= 1'b0;
      if (clear) val <= '0;
      if (frame_strobe) begin
        unique case (state)
          IDLE: begin
            if (frame_class == SINGLE) begin
              cand <= frame_key;
              cnt  <= 4'd1;
              if (DF == 4'd1) begin
                state  <= HELD;
                held   <= 1'b1;
                accept <= 1'b1;
                key    <= frame_key;
                if (!clear) val <= {val[27:0], frame_key};
              end else begin
                state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (frame_class == SINGLE && frame_key == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == DF) begin
                state  <= HELD;
                held   <= 1'b1;
                accept <= 1'b1;
                key    <= cand;
                if (!clear) val <= {val[27:0], cand};
              end
            end else if (frame_class == SINGLE) begin
              // a different key restarts the run rather than aborting it
              cand <= frame_key;
              cnt  <= 4'd1;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (frame_class == EMPTY) begin
              cnt <= 4'd1;
              if (DF == 4'd1) begin
                state <= IDLE;
                held  <= 1'b0;
              end else begin
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (frame_class == EMPTY) begin
              cnt <= cnt_inc;
              if (cnt_inc == DF) begin
                state <= IDLE;
                held  <= 1'b0;
              end
            end else begin
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 active-low hex keypad scanner with frame-level debounce.
//   clk_in, rst_in : clock, synchronous active-high reset
//   row_in         : keypad rows, active-low, asynchronous
//   col_out        : column drive, active-low, one bit low at a time
//   kp (master)    : clear_in in; key_valid_out, key_out,
//                    key_held_out, val_out out
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_COUNT      = 100_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [3:0]                  row_in,
  output logic [3:0]                  col_out,
  hex_keypad_scanner_if.master        kp
);

  localparam int CW = $clog2(SCAN_COUNT + 1);

  logic [3:0]       row_m, row_s;
  logic [CW-1:0]    dwell;
  logic [1:0]       col_idx;
  logic [3:0][3:0]  snap;     // [col][row], 1 = key down
  logic [3:0][3:0]  frame_m;
  logic             col_end, frame_end;
  logic [4:0]       nkeys;
  logic [3:0]       fkey;
  frame_class_t     fclass;

  assign col_end   = (dwell == CW'(SCAN_COUNT));
  assign frame_end = col_end && (col_idx == 2'd3);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      row_m   <= 4'hF;
      row_s   <= 4'hF;
      dwell   <= '0;
      col_idx <= '0;
      col_out <= 4'b1110;
      snap    <= '0;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
      if (col_end) begin
        dwell         <= '0;
        col_idx       <= col_idx + 2'd1;
        col_out       <= {col_out[2:0], col_out[3]};
        snap[col_idx] <= ~row_s;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Column 3 is classified in the same cycle it is captured, so take it
  // straight from the synchronizer instead of the snapshot register.
  always_comb begin
    frame_m    = snap;
    frame_m[3] = ~row_s;
  end

  always_comb begin
    nkeys = '0;
    fkey  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (frame_m[2'(c)][2'(r)]) begin
          nkeys = nkeys + 5'd1;
          fkey  = KEY_MAP[r][c];
        end
      end
    end
    if (nkeys == 5'd0)      fclass = EMPTY;
    else if (nkeys == 5'd1) fclass = SINGLE;
    else                    fclass = MULTI;
  end

  logic        db_accept, db_held;
  logic [3:0]  db_key;
  logic [31:0] db_val;

  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .frame_strobe (frame_end),
    .frame_class  (fclass),
    .frame_key    (fkey),
    .clear        (kp.clear_in),
    .accept       (db_accept),
    .key          (db_key),
    .held         (db_held),
    .val          (db_val)
  );

  assign kp.key_valid_out = db_accept;
  assign kp.key_out       = db_key;
  assign kp.key_held_out  = db_held;
  assign kp.val_out       = db_val;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
module tb_hex_keypad_scanner;

  localparam int SC    = 4;
  localparam int DF    = 2;
  localparam int FRAME = 4 * (SC + 1);

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] mask = '0;   // bit r*4+c = key at (row r, col c) pressed

  hex_keypad_scanner_if kp();

  hex_keypad_scanner #(.SCAN_COUNT(SC), .DEBOUNCE_FRAMES(DF)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .row_in  (row_in),
    .col_out (col_out),
    .kp      (kp)
  );

  always #5 clk_in = ~clk_in;

  // Physical keypad: a row reads low when a pressed key joins it to a low column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(mask[r*4 +: 4] & ~col_out);
  end

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

  // reference model state
  int          cyc;
  logic        m_valid, m_held;
  logic [3:0]  m_key, run_key;
  logic [31:0] m_val;
  int          run_len, empty_run;
  int          n_pass = 0, n_total = 0, dut_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [15:0] kmask(input logic [3:0] k);
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) if (keymap[i] == k) m[i] = 1'b1;
    return m;
  endfunction

  // A key counts as pressed after DF consecutive frames showing only it;
  // released after DF consecutive empty frames.
  task automatic model_frame();
    int n = $countones(mask);
    logic [3:0] k = '0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = keymap[i];
    if (!m_held) begin
      if (n == 1) begin
        if (run_len > 0 && run_key == k) run_len++;
        else begin run_key = k; run_len = 1; end
        if (run_len >= DF) begin
          m_valid = 1'b1; m_key = k; m_val = {m_val[27:0], k};
          m_held = 1'b1; empty_run = 0; run_len = 0;
        end
      end else run_len = 0;
    end else begin
      if (n == 0) begin
        empty_run++;
        if (empty_run >= DF) begin m_held = 1'b0; run_len = 0; end
      end else empty_run = 0;
    end
  endtask

  task automatic tick();
    logic [3:0] ec;
    @(posedge clk_in);
    m_valid = 1'b0;
    if (rst_in) begin
      cyc = 0; m_held = 1'b0; m_key = '0; m_val = '0; run_len = 0; empty_run = 0;
    end else begin
      cyc++;
      if (cyc % FRAME == 0) model_frame();
      if (kp.clear_in) m_val = '0;
    end
    @(negedge clk_in);
    if (kp.key_valid_out === 1'b1) dut_pulses++;
    ec = 4'hF;
    ec[(cyc / (SC + 1)) % 4] = 1'b0;
    check("col_out", col_out, ec);
    check("key_valid", kp.key_valid_out, m_valid);
    check("key_out", kp.key_out, m_key);
    check("key_held", kp.key_held_out, m_held);
    check("val_out", kp.val_out, m_val);
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    mask = m;
    repeat (n * FRAME) tick();
  endtask

  // one frame with clear_in high in its last (frame-end) cycle
  task automatic frame_clear(input logic [15:0] m);
    mask = m;
    repeat (FRAME - 1) tick();
    kp.clear_in = 1'b1;
    tick();
    kp.clear_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  initial begin
    kp.clear_in = 1'b0;
    cyc = 0; m_valid = 0; m_held = 0; m_key = 0; m_val = 0;
    run_key = 0; run_len = 0; empty_run = 0;

    // reset and column walk with idle rows
    do_reset();
    check("rst_col", col_out, 32'hE);
    check("rst_val", kp.val_out, 32'h0);
    repeat (5) tick();
    check("col_at5", col_out, 32'hD);
    repeat (10) tick();
    check("col_at15", col_out, 32'h7);
    repeat (5) tick();
    frames('0, 1);
    check("idle_held", kp.key_held_out, 32'h0);

    // single press of key 6, then release
    dut_pulses = 0;
    frames(kmask(4'h6), 5);
    check("k6_pulses", dut_pulses, 32'd1);
    check("k6_key", kp.key_out, 32'h6);
    check("k6_val", kp.val_out, 32'h6);
    check("k6_held", kp.key_held_out, 32'h1);
    frames('0, 2);
    check("k6_released", kp.key_held_out, 32'h0);

    // digit entry 1 A 0 D
    do_reset();
    dut_pulses = 0;
    frames(kmask(4'h1), 3); frames('0, 2);
    frames(kmask(4'hA), 3); frames('0, 2);
    frames(kmask(4'h0), 3); frames('0, 2);
    frames(kmask(4'hD), 3); frames('0, 2);
    check("entry_val", kp.val_out, 32'h1A0D);
    check("entry_pulses", dut_pulses, 32'd4);

    // bounce rejection
    dut_pulses = 0;
    repeat (3) begin frames(kmask(4'h5), 1); frames('0, 1); end
    check("bounce_none", dut_pulses, 32'd0);
    frames(kmask(4'h5), 1);
    frames(kmask(4'h8), 2);
    check("bounce_pulses", dut_pulses, 32'd1);
    check("bounce_key", kp.key_out, 32'h8);
    frames('0, 2);

    // multi-key, then a held key with a one-frame gap
    dut_pulses = 0;
    frames(kmask(4'h2) | kmask(4'h3), 4);
    check("multi_none", dut_pulses, 32'd0);
    frames('0, 1);
    frames(kmask(4'h9), 3);
    frames('0, 1);
    frames(kmask(4'h9), 3);
    check("gap_pulses", dut_pulses, 32'd1);
    frames('0, 2);

    // clear in the accept cycle
    frames(kmask(4'h7), 1);
    frame_clear(kmask(4'h7));
    check("clr_valid", kp.key_valid_out, 32'h1);
    check("clr_val", kp.val_out, 32'h0);
    check("clr_key", kp.key_out, 32'h7);
    frames('0, 2);

    // reset while confirming
    dut_pulses = 0;
    frames(kmask(4'h4), 1);
    mask = kmask(4'h4);
    repeat (7) tick();
    do_reset();
    frames(kmask(4'h4), 1);
    check("rstmid_pulses", dut_pulses, 32'd0);
    check("rstmid_held", kp.key_held_out, 32'h0);
    frames('0, 1);

    // randomized frame sequences against the model
    for (int it = 0; it < 40; it++) begin
      int sel = $urandom_range(0, 9);
      if (sel < 6) begin
        frames(16'(1) << $urandom_range(0, 15), $urandom_range(1, 4));
      end else if (sel < 8) begin
        frames('0, $urandom_range(1, 3));
      end else if (sel == 8) begin
        int a = $urandom_range(0, 15);
        int b = (a + $urandom_range(1, 15)) % 16;
        frames((16'(1) << a) | (16'(1) << b), $urandom_range(1, 2));
      end else begin
        frame_clear(16'(1) << $urandom_range(0, 15));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
